moving_average: RTL and testbench
=================================

Name: moving_average

Overview:
- Boxcar (moving-average) low-pass filter.
- Sits directly downstream of pulse_generator: that block's out pulse drives sample_stb here, so a new sample is taken at each pulse period.
- Keeps a circular buffer of the last 2^LOG2_WINDOW samples and a running sum.
- Outputs the window mean each time a sample is accepted.

Parameters:
WIDTH, 12, sample width in bits; signed two's complement for x_in and y_out.
LOG2_WINDOW, 3, log2 of the window length; window = 2^LOG2_WINDOW samples, legal range 1..8.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
ena  input  1  block enable; when low, strobes are ignored and all state holds.
sample_stb  input  1  sample strobe, normally pulse_generator.out; sampled every cycle.
x_in  input  WIDTH  signed input sample, valid in any cycle where sample_stb=1.
y_out  output  WIDTH  signed window mean.
y_valid  output  1  one-cycle pulse, high the cycle after a sample is accepted.
primed  output  1  high once the window has been completely filled since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - y_out=0, y_valid=0, primed=0.
  - Internal: sum=0, wr_ptr=0, fill_count=0.
  - Buffer RAM is not cleared; stale contents are masked by fill_count (see below).
- Accept condition: accept = ena & sample_stb & ~rst. Each cycle with accept=1 is one sample.
  - Consecutive-cycle strobes are each processed; no minimum spacing between samples.
- On accept, in the same cycle:
  - old = (fill_count == 2^LOG2_WINDOW) ? buf[wr_ptr] : 0.
  - buf[wr_ptr] <= x_in.
  - sum <= sum + x_in - old.
  - wr_ptr <= wr_ptr + 1, wrapping modulo 2^LOG2_WINDOW.
  - fill_count increments and saturates at 2^LOG2_WINDOW.
- Output update:
  - On the cycle after accept, y_valid=1 and y_out = new_sum >>> LOG2_WINDOW.
  - The shift is arithmetic and rounds toward minus infinity.
  - Latency from strobe to y_valid is exactly 1 cycle.
  - y_out holds its value between updates. y_valid is high for exactly one cycle per accepted sample.
- Sum arithmetic:
  - sum is signed, WIDTH+LOG2_WINDOW bits; it cannot overflow.
  - y_out always fits in WIDTH bits without saturation.
- Fill phase: while fill_count < window, missing samples count as zero, so the output ramps up. Example: constant input c gives k*c/window after k samples.
- primed: goes high in the same cycle as the y_valid that follows the 2^LOG2_WINDOW-th accepted sample. Stays high until reset.
- ena low:
  - Strobes are dropped, not queued.
  - y_out, primed, sum, pointer and buffer all hold.
  - y_valid is 0 in the cycle after any dropped strobe.
- Reset mid-operation: rst wins over a coincident strobe. That sample is discarded and all state returns to reset values on the next edge.
- Buffer implementation: must map to inferred RAM (single write port, one read at wr_ptr). A registered-read variant is allowed only if externally visible timing is unchanged.

Test Plan:
- WIDTH=8, LOG2_WINDOW=2; reset, then 4 strobes with x_in=100 -> y_out sequence 25,50,75,100, each 1 cycle after its strobe; primed rises with the 4th y_valid.
- Continue the same bench: 4 strobes with x_in=20 -> y_out 80,60,40,20; primed stays 1 (exercises wrap-around and oldest-sample subtraction).
- Signed: after reset, strobes -128,-128,-128,-128 -> y_out -32,-64,-96,-128. After reset, a single strobe of -1 -> y_out -1 (floor rounding).
- Back-to-back: sample_stb high for 4 consecutive cycles with x_in=8,16,24,32 -> 4 consecutive y_valid pulses with y_out 2,6,12,20.
- Enable gating: primed at 100, then ena=0 with 3 strobes of x_in=0 -> no y_valid, y_out stays 100. Then ena=1 with one strobe of 0 -> y_out 75.
- Reset mid-run: primed at 100, assert rst for 1 cycle coincident with a strobe -> y_out=0, primed=0, y_valid=0. Next strobe of 100 -> y_out 25. Full integration: drive sample_stb from pulse_generator (12 MHz clk, 120-tick period) -> one y_valid every 120 cycles.

Source files
------------

// File: rtl/moving_average.sv
// Boxcar moving-average filter over the last 2^LOG2_WINDOW signed samples.
// Running sum plus circular buffer; mean is an arithmetic right shift.
module moving_average #(
  parameter int WIDTH       = 12,
  parameter int LOG2_WINDOW = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    sample_stb,
  input  logic signed [WIDTH-1:0] x_in,
  output logic signed [WIDTH-1:0] y_out,
  output logic                    y_valid,
  output logic                    primed
);

  localparam int N  = 1 << LOG2_WINDOW;
  localparam int SW = WIDTH + LOG2_WINDOW;
  localparam logic [LOG2_WINDOW:0] FULL =
    {1'b1, {LOG2_WINDOW{1'b0}}};
  localparam logic [LOG2_WINDOW:0] LAST =
    {1'b0, {LOG2_WINDOW{1'b1}}};

  logic signed [WIDTH-1:0] mem [0:N-1];
  logic [LOG2_WINDOW-1:0]  wr_ptr;
  logic [LOG2_WINDOW:0]    fill_count;
  logic signed [SW-1:0]    sum;

  logic                    accept;
  logic signed [WIDTH-1:0] rd_data;
  logic signed [WIDTH-1:0] old;
  logic signed [SW-1:0]    x_ext;
  logic signed [SW-1:0]    old_ext;
  logic signed [SW-1:0]    sum_next;
  logic signed [SW-1:0]    mean;

  assign accept   = ena & sample_stb & ~rst;
  assign rd_data  = mem[wr_ptr];
  // Stale RAM contents are masked until the window has filled once.
  assign old      = (fill_count == FULL) ? rd_data : '0;
  assign x_ext    = {{LOG2_WINDOW{x_in[WIDTH-1]}}, x_in};
  assign old_ext  = {{LOG2_WINDOW{old[WIDTH-1]}}, old};
  assign sum_next = sum + x_ext - old_ext;
  assign mean     = sum_next >>> LOG2_WINDOW;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= x_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum        <= '0;
      wr_ptr     <= '0;
      fill_count <= '0;
      y_out      <= '0;
      y_valid    <= 1'b0;
      primed     <= 1'b0;
    end else begin
      y_valid <= accept;
      if (accept) begin
        sum    <= sum_next;
        wr_ptr <= wr_ptr + 1'b1;
        y_out  <= mean[WIDTH-1:0];
        if (fill_count != FULL)
          fill_count <= fill_count + 1'b1;
        if (fill_count == LAST)
          primed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_moving_average.sv
// Bench for moving_average: directed plan steps plus random traffic,
// checked against a queue-based window-mean model.
module tb_moving_average;

  localparam int W = 8;
  localparam int L = 2;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                ena;
  logic                sample_stb;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_out;
  logic                y_valid;
  logic                primed;

  int errors = 0;
  int checks = 0;
  int hist[$];
  int exp_y = 0;
  bit exp_p = 0;
  int vcount = 0;

  moving_average #(.WIDTH(W), .LOG2_WINDOW(L)) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .sample_stb(sample_stb),
    .x_in(x_in),
    .y_out(y_out),
    .y_valid(y_valid),
    .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s,
                      input logic signed [W-1:0] x);
    bit acc;
    int tot;
    rst = r;
    ena = e;
    sample_stb = s;
    x_in = x;
    @(posedge clk);
    #1;
    acc = e & s & ~r;
    if (r) begin
      hist.delete();
      exp_y = 0;
      exp_p = 0;
    end else if (acc) begin
      hist.push_back(int'(x));
      if (hist.size() > N) void'(hist.pop_front());
      tot = 0;
      foreach (hist[i]) tot += hist[i];
      exp_y = tot >>> L;
      if (hist.size() == N) exp_p = 1;
    end
    if (y_valid) vcount++;
    check("y_valid", int'(y_valid), int'(acc));
    check("y_out", int'(y_out), exp_y);
    check("primed", int'(primed), int'(exp_p));
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0);
    step(0, 0, 0, '0);
  endtask

  initial begin
    rst = 1;
    ena = 0;
    sample_stb = 0;
    x_in = '0;

    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 1, 8'sd100);
    check("fill_100", int'(y_out), 100);
    check("primed_100", int'(primed), 1);

    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 8'sd20);
      step(0, 1, 0, '0);
    end
    check("wrap_20", int'(y_out), 20);

    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 1, -8'sd128);
    check("neg_full", int'(y_out), -128);

    do_reset();
    step(0, 1, 1, -8'sd1);
    check("floor_m1", int'(y_out), -1);

    do_reset();
    for (int i = 1; i <= 4; i++) step(0, 1, 1, 8'(i * 8));
    check("b2b_last", int'(y_out), 20);

    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 1, 8'sd100);
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
    check("ena_hold", int'(y_out), 100);
    step(0, 1, 1, '0);
    check("ena_resume", int'(y_out), 75);

    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 1, 8'sd100);
    step(1, 1, 1, '0);
    check("rst_y", int'(y_out), 0);
    check("rst_primed", int'(primed), 0);
    step(0, 1, 1, 8'sd100);
    check("post_rst", int'(y_out), 25);

    // Pulse-generator style strobe: one sample every 120 cycles.
    do_reset();
    vcount = 0;
    for (int c = 0; c < 360; c++)
      step(0, 1, (c % 120) == 119, 8'(c / 3));
    check("pulse_count", vcount, 3);

    for (int c = 0; c < 400; c++)
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 2) != 0), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
